// File: rtl/div_iter_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : div_iter_seq_if                                              |
// | Description : Request/result bundle between a requester and div_iter_seq.  |
// |               div_by_zero exists only when DIV_ZERO_DETECT_EN is defined.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface div_iter_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_by_zero;
`endif

    modport master (
        output start, dividend, divisor,
        input  busy, done, quo, rem
`ifdef DIV_ZERO_DETECT_EN
        , input div_by_zero
`endif
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quo, rem
`ifdef DIV_ZERO_DETECT_EN
        , output div_by_zero
`endif
    );
endinterface
`default_nettype wire

// File: rtl/div_iter_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : div_iter_seq                                                 |
// | Description : Sequential non-restoring unsigned divider, one add/sub row   |
// |               reused over WIDTH cycles plus one correction cycle.          |
// |               Optional macro DIV_ZERO_DETECT_EN: zero divisor bypass.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module div_iter_seq #(
    parameter int WIDTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    div_iter_seq_if.slave  bus
);
    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CORR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH:0]     r_p;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic               r_done;

    logic               w_accept;
    logic               w_run_start;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_s;
    logic [WIDTH:0]     w_p_step;
    logic [WIDTH:0]     w_p_corr;

    assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef DIV_ZERO_DETECT_EN
    logic w_zero;
    logic r_dbz;
    assign w_zero          = (bus.divisor == '0);
    assign w_run_start     = w_accept && !w_zero;
    assign bus.div_by_zero = r_dbz;
`else
    assign w_run_start = w_accept;
`endif

    // One non-restoring row: the sign of the previous partial remainder picks add or subtract.
    assign w_m_ext  = {1'b0, r_m};
    assign w_s      = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_p_step = r_p[WIDTH] ? (w_s + w_m_ext) : (w_s - w_m_ext);
    assign w_p_corr = r_p[WIDTH] ? (r_p + w_m_ext) : r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_run_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_CORR;
            S_CORR:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m    <= '0;
            r_a    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m   <= bus.divisor;
                        r_a   <= bus.dividend;
                        r_p   <= '0;
                        r_cnt <= c_cnt_init;
`ifdef DIV_ZERO_DETECT_EN
                        r_dbz <= w_zero;
                        if (w_zero) begin
                            r_quo  <= '1;
                            r_rem  <= bus.dividend;
                            r_done <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_step;
                    r_a   <= {r_a[WIDTH-2:0], ~w_p_step[WIDTH]};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_CORR: begin
                    r_quo  <= r_a;
                    r_rem  <= w_p_corr[WIDTH-1:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN) || (r_state == S_CORR);
    assign bus.done = r_done;
    assign bus.quo  = r_quo;
    assign bus.rem  = r_rem;
endmodule
`default_nettype wire

// File: tb/tb_div_iter_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_div_iter_seq                                              |
// | Description : Self-checking bench for div_iter_seq against integer / and %.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_div_iter_seq;
    localparam int WIDTH = 16;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit c_dz = 1'b1;
`else
    localparam bit c_dz = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    div_iter_seq_if #(.WIDTH(WIDTH)) bif ();
    div_iter_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    // Reference: quotient in the upper half, remainder in the lower half.
    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int q, r;
        if (b == 16'd0) return {16'hFFFF, a};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {q[15:0], r[15:0]};
    endfunction

    function automatic int exp_lat(input logic [15:0] b);
        return (c_dz && b == 16'd0) ? 0 : WIDTH + 1;
    endfunction

    // Issues one request, scrambles the operand inputs while busy, and measures the
    // number of edges after the accepting edge until done is seen.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int nbusy);
        @(negedge clk);
        bif.start = 1'b1; bif.dividend = a; bif.divisor = b;
        @(posedge clk); #1;
        bif.start = 1'b0;
        lat = 0; nbusy = 0;
        while (!bif.done && lat < 100) begin
            bif.dividend = 16'($urandom); bif.divisor = 16'($urandom);
            if (bif.busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.start = 1'b0; bif.dividend = '0; bif.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bif.busy); end
        n_vec++; if (bif.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bif.done); end
        n_vec++; if (bif.quo !== 16'd0 || bif.rem !== 16'd0) begin
            n_err++; $display("FAIL reset_result got q=%0d r=%0d exp 0/0", bif.quo, bif.rem);
        end
`ifdef DIV_ZERO_DETECT_EN
        n_vec++; if (bif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b exp 0", bif.div_by_zero); end
`endif
    endtask

    task automatic test_basic();
        int lat, nb;
        run_div(16'd13869, 16'd900, lat, nb);
        n_vec++; if (lat != 17) begin n_err++; $display("FAIL basic_latency got %0d exp 17", lat); end
        n_vec++; if (nb != 17) begin n_err++; $display("FAIL basic_busy_cycles got %0d exp 17", nb); end
        n_vec++; if (bif.quo !== 16'd15 || bif.rem !== 16'd369) begin
            n_err++; $display("FAIL basic_result got q=%0d r=%0d exp 15/369", bif.quo, bif.rem);
        end
        n_vec++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b exp 0", bif.busy); end
        @(posedge clk); #1;
        n_vec++; if (bif.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b exp 0", bif.done); end
        n_vec++; if (bif.quo !== 16'd15 || bif.rem !== 16'd369) begin
            n_err++; $display("FAIL basic_hold got q=%0d r=%0d exp 15/369", bif.quo, bif.rem);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        run_div(16'd901, 16'd300, lat, nb);
        n_vec++; if (lat != 17 || bif.quo !== 16'd3 || bif.rem !== 16'd1) begin
            n_err++; $display("FAIL b2b_first got lat=%0d q=%0d r=%0d exp 17/3/1", lat, bif.quo, bif.rem);
        end
        // Second start is presented during the done cycle itself.
        bif.start = 1'b1; bif.dividend = 16'd15; bif.divisor = 16'd3;
        @(posedge clk); #1;
        bif.start = 1'b0;
        n_vec++; if (bif.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b exp 1", bif.busy); end
        lat = 0;
        while (!bif.done && lat < 100) begin
            if (lat == 8) begin
                n_vec++; if (bif.quo !== 16'd3 || bif.rem !== 16'd1) begin
                    n_err++; $display("FAIL b2b_hold got q=%0d r=%0d exp 3/1", bif.quo, bif.rem);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        n_vec++; if (lat != 17 || bif.quo !== 16'd5 || bif.rem !== 16'd0) begin
            n_err++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d exp 17/5/0", lat, bif.quo, bif.rem);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] ta [5] = '{16'd40000, 16'd65535, 16'd3000, 16'd21, 16'd5};
        logic [15:0] tb [5] = '{16'd12000, 16'd1,     16'd2000, 16'd20, 16'd9};
        logic [15:0] tq [5] = '{16'd3,     16'd65535, 16'd1,    16'd1,  16'd0};
        logic [15:0] tr [5] = '{16'd4000,  16'd0,     16'd1000, 16'd1,  16'd5};
        int lat, nb;
        for (int i = 0; i < 5; i++) begin
            run_div(ta[i], tb[i], lat, nb);
            n_vec++; if (lat != 17 || bif.quo !== tq[i] || bif.rem !== tr[i]) begin
                n_err++;
                $display("FAIL boundary_%0d %0d/%0d got lat=%0d q=%0d r=%0d exp 17/%0d/%0d",
                         i, ta[i], tb[i], lat, bif.quo, bif.rem, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, nb;
        @(negedge clk);
        bif.start = 1'b1; bif.dividend = 16'd6200; bif.divisor = 16'd1598;
        @(posedge clk); #1;
        bif.start = 1'b0;
        lat = 0;
        while (!bif.done && lat < 100) begin
            if (lat == 5) begin
                bif.start = 1'b1; bif.dividend = 16'd9801; bif.divisor = 16'd310;
            end else begin
                bif.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bif.start = 1'b0;
        n_vec++; if (lat != 17 || bif.quo !== 16'd3 || bif.rem !== 16'd1406) begin
            n_err++; $display("FAIL ignore_start got lat=%0d q=%0d r=%0d exp 17/3/1406", lat, bif.quo, bif.rem);
        end
        run_div(16'd9801, 16'd310, lat, nb);
        n_vec++; if (lat != 17 || bif.quo !== 16'd31 || bif.rem !== 16'd191) begin
            n_err++; $display("FAIL fresh_start got lat=%0d q=%0d r=%0d exp 17/31/191", lat, bif.quo, bif.rem);
        end
    endtask

    task automatic test_reset_midop();
        int lat, nb;
        bit seen;
        @(negedge clk);
        bif.start = 1'b1; bif.dividend = 16'd13869; bif.divisor = 16'd900;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.quo !== 16'd0 || bif.rem !== 16'd0) begin
            n_err++; $display("FAIL midop_reset got busy=%b done=%b q=%0d r=%0d exp 0/0/0/0",
                              bif.busy, bif.done, bif.quo, bif.rem);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bif.done || bif.busy) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midop_no_done got activity=%b exp 0", seen); end
        run_div(16'd15, 16'd3, lat, nb);
        n_vec++; if (lat != 17 || bif.quo !== 16'd5 || bif.rem !== 16'd0) begin
            n_err++; $display("FAIL midop_recover got lat=%0d q=%0d r=%0d exp 17/5/0", lat, bif.quo, bif.rem);
        end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_div(16'd1234, 16'd0, lat, nb);
        n_vec++; if (lat != exp_lat(16'd0) || bif.quo !== 16'hFFFF || bif.rem !== 16'd1234) begin
            n_err++; $display("FAIL div_zero got lat=%0d q=%0h r=%0d exp %0d/ffff/1234",
                              lat, bif.quo, bif.rem, exp_lat(16'd0));
        end
        n_vec++; if (nb != (c_dz ? 0 : 17)) begin
            n_err++; $display("FAIL div_zero_busy got %0d exp %0d", nb, c_dz ? 0 : 17);
        end
`ifdef DIV_ZERO_DETECT_EN
        n_vec++; if (bif.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_set got %b exp 1", bif.div_by_zero); end
        @(posedge clk); #1;
        n_vec++; if (bif.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_hold got %b exp 1", bif.div_by_zero); end
`endif
        run_div(16'd100, 16'd7, lat, nb);
        n_vec++; if (lat != 17 || bif.quo !== 16'd14 || bif.rem !== 16'd2) begin
            n_err++; $display("FAIL after_zero got lat=%0d q=%0d r=%0d exp 17/14/2", lat, bif.quo, bif.rem);
        end
`ifdef DIV_ZERO_DETECT_EN
        n_vec++; if (bif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_clear got %b exp 0", bif.div_by_zero); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [31:0] e;
        int lat, nb;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(1, 15));
                1:       b = 16'($urandom);
                2:       b = (i % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 255));
                default: b = a - 16'($urandom_range(0, 3));
            endcase
            e = ref_div(a, b);
            run_div(a, b, lat, nb);
            n_vec++; if (lat != exp_lat(b) || bif.quo !== e[31:16] || bif.rem !== e[15:0]) begin
                n_err++;
                $display("FAIL random_%0d %0d/%0d got lat=%0d q=%0d r=%0d exp %0d/%0d/%0d",
                         i, a, b, lat, bif.quo, bif.rem, exp_lat(b), e[31:16], e[15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundaries();
        test_start_while_busy();
        test_reset_midop();
        test_div_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
